// File: rtl/bbc_pkg.sv
// Shared types, defaults and the hex display lookup
// for the up/down count monitor.
package bbc_pkg;

  localparam int CNT_W_DEF  = 4;
  localparam int WRAP_W_DEF = 8;

  typedef enum logic [1:0] {
    INIT,
    TRACK,
    FAULT
  } state_e;

  // Bit order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_ZERO = 7'b0111111;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    s = SEG_ZERO;
    case (v)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      4'hF: s = 7'b1110001;
      default: s = SEG_ZERO;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bbc_sat_counter.sv
// Saturating incrementer with synchronous clear.
// Ports: clk, reset, clr_i, inc_i -> cnt_o.
module bbc_sat_counter
  import bbc_pkg::*;
#(
  parameter int W = WRAP_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] MAXV = '1;
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && cnt_q != MAXV)
      cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/bbc_count_monitor.sv
// Checks each count sample for a legal +/-1 step, tallies wraps,
// flags illegal steps, and drives a hex display of the last sample.
// Ports: clk, reset, count_i, dir_i, clr_i -> seg_o, up_wrap_o,
// down_wrap_o, up_wraps_o, down_wraps_o, fault_o, irq_o.
module bbc_count_monitor
  import bbc_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  count_i,
  input  logic              dir_i,
  input  logic              clr_i,
  output logic [6:0]        seg_o,
  output logic              up_wrap_o,
  output logic              down_wrap_o,
  output logic [WRAP_W-1:0] up_wraps_o,
  output logic [WRAP_W-1:0] down_wraps_o,
  output logic              fault_o,
  output logic              irq_o
);

  localparam logic [CNT_W-1:0] MAXV = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] prev_q;
  logic             dir_q;
  logic [6:0]       seg_q;
  logic             up_wrap_q;
  logic             down_wrap_q;
  logic             fault_q;
  logic             irq_q;

  logic [CNT_W-1:0] inc_v;
  logic [CNT_W-1:0] dec_v;
  logic             hold;
  logic             step_up;
  logic             step_dn;
  logic             in_track;
  logic             up_ev;
  logic             dn_ev;
  logic             bad;

  assign inc_v = prev_q + ONE;
  assign dec_v = prev_q - ONE;

  // dir_q is the direction the counter used to produce count_i.
  always_comb begin
    in_track = (state_q == TRACK);
    hold     = (count_i == prev_q);
    step_up  = dir_q && (count_i == inc_v);
    step_dn  = !dir_q && (count_i == dec_v);
    up_ev    = in_track && step_up && (prev_q == MAXV);
    dn_ev    = in_track && step_dn && (prev_q == '0);
    bad      = in_track && !(hold || step_up || step_dn);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      prev_q      <= '0;
      dir_q       <= 1'b0;
      seg_q       <= SEG_ZERO;
      up_wrap_q   <= 1'b0;
      down_wrap_q <= 1'b0;
      fault_q     <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      prev_q      <= count_i;
      dir_q       <= dir_i;
      seg_q       <= hex7(4'(count_i));
      up_wrap_q   <= 1'b0;
      down_wrap_q <= 1'b0;
      irq_q       <= 1'b0;
      if (clr_i) begin
        state_q <= INIT;
        fault_q <= 1'b0;
      end else begin
        unique case (state_q)
          INIT: state_q <= TRACK;
          TRACK: begin
            up_wrap_q   <= up_ev;
            down_wrap_q <= dn_ev;
            if (bad) begin
              state_q <= FAULT;
              fault_q <= 1'b1;
              irq_q   <= 1'b1;
            end
          end
          default: state_q <= FAULT;
        endcase
      end
    end
  end

  bbc_sat_counter #(.W(WRAP_W)) u_up_tally (
    .clk   (clk),
    .reset (reset),
    .clr_i (clr_i),
    .inc_i (up_ev && !clr_i),
    .cnt_o (up_wraps_o)
  );

  bbc_sat_counter #(.W(WRAP_W)) u_dn_tally (
    .clk   (clk),
    .reset (reset),
    .clr_i (clr_i),
    .inc_i (dn_ev && !clr_i),
    .cnt_o (down_wraps_o)
  );

  assign seg_o       = seg_q;
  assign up_wrap_o   = up_wrap_q;
  assign down_wrap_o = down_wrap_q;
  assign fault_o     = fault_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_bbc_count_monitor.sv
// Directed and random stimulus for bbc_count_monitor,
// compared every cycle against a behavioural model.
module tb_bbc_count_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] count_i = '0;
  logic       dir_i = 1'b0;
  logic       clr_i = 1'b0;
  logic [6:0] seg_o;
  logic       up_wrap_o;
  logic       down_wrap_o;
  logic [7:0] up_wraps_o;
  logic [7:0] down_wraps_o;
  logic       fault_o;
  logic       irq_o;

  always #5 clk = ~clk;

  bbc_count_monitor #(.CNT_W(4), .WRAP_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .count_i      (count_i),
    .dir_i        (dir_i),
    .clr_i        (clr_i),
    .seg_o        (seg_o),
    .up_wrap_o    (up_wrap_o),
    .down_wrap_o  (down_wrap_o),
    .up_wraps_o   (up_wraps_o),
    .down_wraps_o (down_wraps_o),
    .fault_o      (fault_o),
    .irq_o        (irq_o)
  );

  logic [6:0] seg_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int errors = 0;
  int checks = 0;

  // Model: phase 0 = capture only, 1 = checking, 2 = faulted.
  int m_phase, m_prev, m_dir, m_up, m_dn;
  int m_fault, m_eu, m_ed, m_irq, m_seg;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int c, input int d, input int cl,
                       input int rs);
    int delta;
    bit legal;
    m_eu = 0; m_ed = 0; m_irq = 0;
    if (rs != 0) begin
      m_phase = 0; m_prev = 0; m_dir = 0; m_up = 0; m_dn = 0;
      m_fault = 0; m_seg = 7'h3F;
      return;
    end
    if (cl != 0) begin
      m_phase = 0; m_fault = 0; m_up = 0; m_dn = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      delta = (c - m_prev + 16) % 16;
      legal = (delta == 0) || (delta == 1 && m_dir == 1)
           || (delta == 15 && m_dir == 0);
      if (!legal) begin
        m_phase = 2; m_fault = 1; m_irq = 1;
      end else if (delta == 1 && c == 0) begin
        m_eu = 1; m_up = (m_up < 255) ? m_up + 1 : 255;
      end else if (delta == 15 && c == 15) begin
        m_ed = 1; m_dn = (m_dn < 255) ? m_dn + 1 : 255;
      end
    end
    m_prev = c; m_dir = d; m_seg = int'(seg_tab[c]);
  endtask

  task automatic cyc(input int c, input int d, input int cl = 0,
                     input int rs = 0);
    @(negedge clk);
    count_i = 4'(c); dir_i = d[0]; clr_i = cl[0]; reset = rs[0];
    @(posedge clk);
    model(c, d, cl, rs);
    #1;
    chk("seg", 32'(seg_o), 32'(m_seg));
    chk("up_wrap", 32'(up_wrap_o), 32'(m_eu));
    chk("down_wrap", 32'(down_wrap_o), 32'(m_ed));
    chk("up_wraps", 32'(up_wraps_o), 32'(m_up));
    chk("down_wraps", 32'(down_wraps_o), 32'(m_dn));
    chk("fault", 32'(fault_o), 32'(m_fault));
    chk("irq", 32'(irq_o), 32'(m_irq));
  endtask

  initial begin
    int cur, dcur, r, nxt;
    m_phase = 0; m_prev = 0; m_dir = 0; m_up = 0; m_dn = 0;
    m_fault = 0; m_eu = 0; m_ed = 0; m_irq = 0; m_seg = 7'h3F;

    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 1);
    chk("reset_seg", 32'(seg_o), 32'h3F);
    chk("reset_fault", 32'(fault_o), 32'd0);

    // Up-count through a wrap.
    for (int i = 0; i < 16; i++) cyc(i, 1);
    cyc(0, 1);
    chk("up_wrap_pulse", 32'(up_wrap_o), 32'd1);
    cyc(1, 1);
    chk("seg_one", 32'(seg_o), 32'h06);
    chk("up_wraps_one", 32'(up_wraps_o), 32'd1);

    // Turn around and down-count through a wrap.
    cyc(2, 1); cyc(3, 0);
    cyc(2, 0); cyc(1, 0); cyc(0, 0); cyc(15, 0);
    chk("down_wrap_pulse", 32'(down_wrap_o), 32'd1);
    cyc(14, 0);
    chk("down_wraps_one", 32'(down_wraps_o), 32'd1);

    // Jump 5 -> 7 while counting up.
    cyc(14, 1);
    cyc(15, 1);
    for (int i = 0; i <= 5; i++) cyc(i, 1);
    cyc(7, 1);
    chk("jump_irq", 32'(irq_o), 32'd1);
    for (int i = 8; i < 18; i++) cyc(i % 16, 1);
    chk("fault_sticky", 32'(fault_o), 32'd1);

    // Wrong-direction step 9 -> 8, then clear and resume.
    cyc(8, 1, 1);
    cyc(9, 1);
    cyc(8, 1);
    chk("wrong_dir_fault", 32'(fault_o), 32'd1);
    cyc(8, 1, 1);
    chk("clr_fault", 32'(fault_o), 32'd0);
    cyc(3, 1);
    for (int i = 4; i < 16; i++) cyc(i, 1);
    cyc(0, 1);
    chk("resume_wrap", 32'(up_wraps_o), 32'd1);

    // 300 up-wraps: tally saturates, pulse keeps coming.
    for (int w = 0; w < 300; w++)
      for (int i = 1; i <= 16; i++) cyc(i % 16, 1);
    chk("sat_tally", 32'(up_wraps_o), 32'd255);
    chk("sat_pulse", 32'(up_wrap_o), 32'd1);

    // Clear coincident with 15 -> 0, then reset mid-fault.
    for (int i = 1; i < 16; i++) cyc(i, 1);
    cyc(0, 1, 1);
    chk("clr_wrap_pulse", 32'(up_wrap_o), 32'd0);
    chk("clr_wrap_tally", 32'(up_wraps_o), 32'd0);
    cyc(1, 1); cyc(2, 1); cyc(9, 1);
    cyc(9, 1);
    cyc(6, 1, 0, 1);
    chk("reset_mid_seg", 32'(seg_o), 32'h3F);
    chk("reset_mid_fault", 32'(fault_o), 32'd0);

    // Random walk with occasional jumps, holds, flips and clears.
    cur = 0; dcur = 1;
    cyc(cur, dcur);
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 199);
      if (r < 2) nxt = $urandom_range(0, 15);
      else if (r < 30) nxt = cur;
      else nxt = dcur ? (cur + 1) % 16 : (cur + 15) % 16;
      cur = nxt;
      if ($urandom_range(0, 19) == 0) dcur = 1 - dcur;
      cyc(cur, dcur, ($urandom_range(0, 99) < 3) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
